// File: rtl/bank_pkg.sv
// bank_pkg
//   Shared definitions for the teller wait-time estimator.
//   - state_t   : control FSM encoding (IDLE, DIV, DONE)
//   - div_width : width of the internal dividend/divisor/quotient datapath,
//                 wide enough for pcount*SERVICE_TIME + tcount - 1.
package bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int div_width(input int pcount_w, input int st_w);
      return pcount_w + st_w + 1;
   endfunction

endpackage

// File: rtl/wtime_div.sv
// wtime_div
//   Iterative restoring divider, one quotient bit per clock, MSB first.
//   A start pulse loads the operands; exactly DIV_W iterations follow.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     start     : load dividend/divisor and begin dividing
//     dividend  : DIV_W-bit unsigned dividend
//     divisor   : DIV_W-bit unsigned divisor (caller guarantees non-zero)
//     done      : high during the cycle whose closing edge runs the last
//                 iteration; quotient is valid while done is high
//     quotient  : DIV_W-bit quotient (result of the final iteration)
module wtime_div
   import bank_pkg::*;
#(
   parameter int DIV_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             done,
   output logic [DIV_W-1:0] quotient
);

   localparam int CNT_W = $clog2(DIV_W + 1);

   logic [DIV_W:0]   rem_reg;
   logic [DIV_W-1:0] quo_reg;
   logic [DIV_W-1:0] dsr_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;

   logic [DIV_W+1:0] shifted;
   logic [DIV_W+1:0] rem_next;
   logic             bit_q;

   // quo_reg doubles as the dividend shift register: its MSB feeds the
   // partial remainder while the new quotient bit enters at the LSB.
   always_comb begin
      shifted  = {rem_reg, quo_reg[DIV_W-1]};
      bit_q    = (shifted >= {2'b00, dsr_reg});
      rem_next = bit_q ? (shifted - {2'b00, dsr_reg}) : shifted;
      done     = busy_reg && (cnt_reg == CNT_W'(DIV_W - 1));
      quotient = {quo_reg[DIV_W-2:0], bit_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_reg  <= '0;
         quo_reg  <= '0;
         dsr_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
      end else if (start) begin
         rem_reg  <= '0;
         quo_reg  <= dividend;
         dsr_reg  <= divisor;
         cnt_reg  <= '0;
         busy_reg <= 1'b1;
      end else if (busy_reg) begin
         // remainder always stays below the divisor, so it fits DIV_W+1 bits
         rem_reg  <= (DIV_W + 1)'(rem_next);
         quo_reg  <= {quo_reg[DIV_W-2:0], bit_q};
         cnt_reg  <= cnt_reg + CNT_W'(1);
         if (done) busy_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/wait_time_calc.sv
// wait_time_calc
//   Estimates customer wait time: wtime = ceil(pcount*SERVICE_TIME / tcount).
//   Ready/valid request in, ready/valid response out, one request in flight.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     req_valid   : request present
//     req_ready   : high only while idle
//     pcount      : customers waiting (sampled on accept)
//     tcount      : tellers open (sampled on accept)
//     resp_valid  : result valid, held until resp_ready
//     resp_ready  : consumer takes the result
//     wtime       : wait time (all ones when clamped or tcount was 0)
//     err         : tcount was 0
//     sat         : quotient did not fit in WTIME_W bits
module wait_time_calc
   import bank_pkg::*;
#(
   parameter int PCOUNT_W     = 3,
   parameter int TCOUNT_W     = 2,
   parameter int SERVICE_TIME = 3,
   parameter int ST_W         = 2,
   parameter int WTIME_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [PCOUNT_W-1:0] pcount,
   input  logic [TCOUNT_W-1:0] tcount,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [WTIME_W-1:0]  wtime,
   output logic                err,
   output logic                sat
);

   localparam int DIV_W = div_width(PCOUNT_W, ST_W);
   // common width for comparing the quotient against the output maximum
   localparam int MW = (DIV_W > WTIME_W) ? DIV_W : WTIME_W;
   localparam logic [MW-1:0] WMAX = MW'({WTIME_W{1'b1}});

   state_t           state_reg;
   logic             zero_reg;
   logic             start;
   logic [DIV_W-1:0] dividend;
   logic [DIV_W-1:0] divisor;
   logic             div_done;
   logic [DIV_W-1:0] quotient;
   logic [MW-1:0]    quo_ext;

   // Adding tcount-1 before dividing turns the floor division into ceiling.
   always_comb begin
      start    = req_valid && req_ready && (tcount != '0);
      dividend = DIV_W'(pcount) * DIV_W'(SERVICE_TIME) + DIV_W'(tcount) - DIV_W'(1);
      divisor  = DIV_W'(tcount);
      quo_ext  = MW'(quotient);
   end

   wtime_div #(
      .DIV_W(DIV_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .done     (div_done),
      .quotient (quotient)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         zero_reg   <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         wtime      <= '0;
         err        <= 1'b0;
         sat        <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  wtime     <= '0;
                  err       <= 1'b0;
                  sat       <= 1'b0;
                  // a zero teller count skips the divider and answers next edge
                  zero_reg  <= (tcount == '0);
                  state_reg <= ST_DIV;
               end
            end
            ST_DIV: begin
               if (zero_reg) begin
                  err        <= 1'b1;
                  wtime      <= '1;
                  resp_valid <= 1'b1;
                  state_reg  <= ST_DONE;
               end else if (div_done) begin
                  if (quo_ext > WMAX) begin
                     wtime <= '1;
                     sat   <= 1'b1;
                  end else begin
                     wtime <= WTIME_W'(quo_ext);
                  end
                  resp_valid <= 1'b1;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state_reg  <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wait_time_calc.sv
// tb_wait_time_calc
//   Directed plus randomized stimulus against a plain-arithmetic model.
//   A second instance with WTIME_W=4 shares all inputs to exercise clamping.
module tb_wait_time_calc;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] pcount;
   logic [1:0] tcount;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] wtime;
   logic       err;
   logic       sat;

   logic       req_ready2;
   logic       resp_valid2;
   logic [3:0] wtime2;
   logic       err2;
   logic       sat2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wait_time_calc dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .pcount     (pcount),
      .tcount     (tcount),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .wtime      (wtime),
      .err        (err),
      .sat        (sat)
   );

   wait_time_calc #(
      .WTIME_W(4)
   ) dut_narrow (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready2),
      .pcount     (pcount),
      .tcount     (tcount),
      .resp_valid (resp_valid2),
      .resp_ready (resp_ready),
      .wtime      (wtime2),
      .err        (err2),
      .sat        (sat2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: ceiling of p*3/t, clamped to the output width; t==0 is an error.
   function automatic void model(input int p, input int t, input int w_w,
                                 output int w, output int e, output int s);
      int q;
      int wmax;
      wmax = (1 << w_w) - 1;
      if (t == 0) begin
         w = wmax; e = 1; s = 0;
      end else begin
         q = (p * 3) / t;
         if ((p * 3) % t != 0) q = q + 1;
         e = 0;
         if (q > wmax) begin
            w = wmax; s = 1;
         end else begin
            w = q; s = 0;
         end
      end
   endfunction

   // Called just after a falling edge with the DUT idle.
   task automatic do_req(input int p, input int t, input int hold);
      int w, e, s, w2, e2, s2, lat;
      model(p, t, 8, w, e, s);
      model(p, t, 4, w2, e2, s2);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      pcount    = 3'(p);
      tcount    = 2'(t);
      @(negedge clk);
      req_valid = 1'b0;
      pcount    = 3'($urandom);
      tcount    = 2'($urandom);
      check("req_ready_busy", req_ready, 0);
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", lat, (t == 0) ? 1 : 6);
      check("wtime", wtime, w);
      check("err", err, e);
      check("sat", sat, s);
      check("resp_valid_n", resp_valid2, 1);
      check("wtime_n", wtime2, w2);
      check("err_n", err2, e2);
      check("sat_n", sat2, s2);
      $display("txn p=%0d t=%0d hold=%0d lat=%0d wtime=%0d err=%0d sat=%0d wtime_n=%0d sat_n=%0d",
               p, t, hold, lat, wtime, err, sat, wtime2, sat2);
      // stray requests while a result is pending must be ignored
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         pcount    = 3'($urandom);
         tcount    = 2'($urandom);
         @(negedge clk);
         check("hold_wtime", wtime, w);
         check("hold_resp_valid", resp_valid, 1);
         check("hold_req_ready", req_ready, 0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("handoff_resp_valid", resp_valid, 0);
      check("handoff_req_ready", req_ready, 1);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      pcount     = '0;
      tcount     = '0;
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_wtime", wtime, 0);
      check("rst_err", err, 0);
      check("rst_sat", sat, 0);
      rst = 1'b0;

      // first accept at the first edge after reset release
      do_req(7, 1, 0);
      do_req(5, 2, 1);
      do_req(4, 3, 0);
      do_req(0, 3, 0);
      do_req(6, 0, 2);
      do_req(7, 3, 5);

      // reset in the middle of a division
      req_valid = 1'b1;
      pcount    = 3'd5;
      tcount    = 2'd2;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_req_ready", req_ready, 1);
      check("midrst_resp_valid", resp_valid, 0);
      check("midrst_wtime", wtime, 0);
      check("midrst_err", err, 0);
      check("midrst_sat", sat, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("midrst_no_resp", resp_valid, 0);
      end
      do_req(2, 1, 0);

      // full sweep of the input space
      for (int p = 0; p < 8; p++) begin
         for (int t = 0; t < 4; t++) begin
            do_req(p, t, 0);
         end
      end

      // randomized requests with random consumer back-pressure
      for (int i = 0; i < 24; i++) begin
         do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wait_time_calc.md
WAIT_TIME_CALC -- requirements
Module: wait_time_calc

Interface
REQ-001 Parameter PCOUNT_W, default 3, width of the customer (person) count.
REQ-002 Parameter TCOUNT_W, default 2, width of the open-teller count.
REQ-003 Parameter SERVICE_TIME, default 3, per-customer service time in time units, range 1..2^ST_W-1.
REQ-004 Parameter ST_W, default 2, width of SERVICE_TIME.
REQ-005 Parameter WTIME_W, default 8, width of the wait-time result.
REQ-006 clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block can accept a request.
REQ-010 pcount  input  PCOUNT_W  customers waiting, sampled on accept.
REQ-011 tcount  input  TCOUNT_W  tellers open, sampled on accept.
REQ-012 resp_valid  output  1  result valid.
REQ-013 resp_ready  input  1  consumer takes the result.
REQ-014 wtime  output  WTIME_W  estimated wait time.
REQ-015 err  output  1  result invalid because tcount was 0.
REQ-016 sat  output  1  true quotient exceeded 2^WTIME_W-1 and wtime is clamped.

Function
REQ-017 Result SHALL be wtime = ceil(pcount*SERVICE_TIME / tcount), computed on DIV_W = PCOUNT_W+ST_W+1 bit unsigned arithmetic.
REQ-018 FSM states: IDLE, DIV, DONE; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept = req_valid & req_ready at a rising edge; pcount and tcount SHALL be captured only on accept.
REQ-020 On accept with tcount != 0: dividend <= pcount*SERVICE_TIME + tcount - 1, divisor <= tcount, iteration counter <= 0, state -> DIV.
REQ-021 DIV SHALL perform one restoring-division quotient bit per cycle, MSB first, for exactly DIV_W cycles; after the DIV_W-th iteration, state -> DONE.
REQ-022 Latency: resp_valid SHALL be 1 exactly DIV_W rising edges after the accept edge (6 with defaults).
REQ-023 On accept with tcount == 0: state -> DONE at the next edge, err=1, wtime=all ones, sat=0; the divider is not run.
REQ-024 If the quotient exceeds 2^WTIME_W-1: wtime = all ones, sat=1; otherwise sat=0 and wtime = the zero-extended quotient.
REQ-025 pcount == 0 with tcount != 0 SHALL yield wtime=0, err=0, sat=0 at normal latency.
REQ-026 In DONE, wtime, err and sat SHALL be stable and resp_valid SHALL stay 1 until resp_ready=1.
REQ-027 resp_valid & resp_ready at an edge SHALL return the state to IDLE; req_ready SHALL rise in the cycle after the handoff, with no same-cycle back-to-back accept.
REQ-028 req_valid, pcount and tcount SHALL be ignored outside IDLE.
REQ-029 err, sat and wtime SHALL be cleared to 0 on every accept.

Reset
REQ-030 rst=1 SHALL immediately force: state IDLE, req_ready=1, resp_valid=0, wtime=0, err=0, sat=0, divider registers and counter 0.
REQ-031 Reset during DIV or DONE SHALL discard the in-flight request with no response.
REQ-032 The first accept SHALL be possible at the first rising edge after rst deasserts.

Structure
REQ-033 The FSM state encoding and the DIV_W width derivation SHALL reside in shared package bank_pkg.
REQ-034 The iterative divider SHALL be the sub-module wtime_div (start, dividend, divisor in; done, quotient out), DIV_W-parametrised; wait_time_calc owns the handshake, the pre-add, saturation and err.

Verification (default parameters)
REQ-035 pcount=7, tcount=1 accepted -> resp_valid 6 edges later, wtime=21, err=0, sat=0.
REQ-036 pcount=5, tcount=2 -> wtime=8 (ceil 7.5); pcount=4, tcount=3 -> wtime=4; pcount=0, tcount=3 -> wtime=0.
REQ-037 tcount=0, pcount=6 -> resp_valid 1 edge after accept, err=1, wtime=255.
REQ-038 pcount=7, tcount=3 with resp_ready held 0 for 5 cycles in DONE -> wtime=7 stable throughout, req_ready=0, a new req_valid is ignored; handoff -> req_ready=1 the next cycle.
REQ-039 rst pulsed mid-DIV -> outputs zero and req_ready=1 immediately, no resp_valid; a following request (pcount=2, tcount=1) -> wtime=6.
REQ-040 Sweep all 32 pcount/tcount pairs -> every result matches REQ-017/REQ-023; a build with SERVICE_TIME=3, WTIME_W=4 and pcount=7, tcount=1 -> sat=1, wtime=15.
